// File: rtl/mem_bist_pkg.sv
// Shared types and constants for the memory BIST controller and its
// expected-data generator.
package mem_bist_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WRITE  = 2'd1;
    localparam logic [1:0] ST_READ   = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    typedef enum logic [1:0] {
        PAT_ZERO = 2'd0,
        PAT_ONE  = 2'd1,
        PAT_CHKR = 2'd2,
        PAT_ADDR = 2'd3
    } pat_e;

    // Even addresses get 0xAAAA-style words (bit0=0); odd addresses the inverse.
    localparam logic [63:0] CHKR_EVEN = {4{16'hAAAA}};
    localparam logic [63:0] CHKR_ODD  = ~CHKR_EVEN;

endpackage

// File: rtl/mem_bist_pattern.sv
// Combinational expected-data generator, shared by the write path and the
// read-compare path so both always agree on the pattern.
module mem_bist_pattern
    import mem_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  pat_e                  pattern,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data
);

    // Widened copy lets address-as-data zero-extend or truncate without a
    // zero-width replication when the widths match.
    logic [DATA_WIDTH+ADDR_WIDTH-1:0] addr_ext;

    assign addr_ext = {{DATA_WIDTH{1'b0}}, addr};

    always_comb begin
        data = '0;
        case (pattern)
            PAT_ZERO: data = '0;
            PAT_ONE:  data = '1;
            PAT_CHKR: data = addr[0] ? CHKR_ODD[DATA_WIDTH-1:0] : CHKR_EVEN[DATA_WIDTH-1:0];
            PAT_ADDR: data = addr_ext[DATA_WIDTH-1:0];
            default:  data = '0;
        endcase
    end

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory BIST master: writes a pattern to every address, reads it all back,
// and reports error count, first failing address, pass and timeout status.
module mem_bist_ctrl
    import mem_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [1:0]            pattern_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic [ADDR_WIDTH:0]   err_cnt_o,
    output logic [ADDR_WIDTH-1:0] first_fail_addr_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  wr_rd_o,
    output logic                  valid_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  ready_i
);

    localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] cnt;
    pat_e                  pat_q;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [DATA_WIDTH-1:0] exp_data;
    logic                  active;
    logic                  hs;
    logic                  mismatch;
    logic [ADDR_WIDTH:0]   err_nxt;

    mem_bist_pattern #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_pattern (
        .pattern(pat_q),
        .addr   (cnt),
        .data   (exp_data)
    );

    assign active   = (state == ST_WRITE) || (state == ST_READ);
    assign valid_o  = active;
    assign wr_rd_o  = (state == ST_WRITE);
    assign addr_o   = active ? cnt : '0;
    assign wdata_o  = wr_rd_o ? exp_data : '0;
    assign busy_o   = (state != ST_IDLE);
    assign done_o   = (state == ST_FINISH);

    assign hs       = active && ready_i;
    assign mismatch = (state == ST_READ) && ready_i && (rdata_i != exp_data);
    assign err_nxt  = err_cnt_o + {{ADDR_WIDTH{1'b0}}, mismatch};

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            pat_q             <= PAT_ZERO;
            wait_cnt          <= '0;
            err_cnt_o         <= '0;
            first_fail_addr_o <= '0;
            pass_o            <= 1'b0;
            timeout_o         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        pat_q             <= pat_e'(pattern_i);
                        cnt               <= '0;
                        wait_cnt          <= '0;
                        err_cnt_o         <= '0;
                        first_fail_addr_o <= '0;
                        pass_o            <= 1'b0;
                        timeout_o         <= 1'b0;
                        state             <= ST_WRITE;
                    end
                end
                ST_WRITE, ST_READ: begin
                    if (hs) begin
                        wait_cnt <= '0;
                        if (mismatch) begin
                            err_cnt_o <= err_nxt;
                            if (err_cnt_o == '0) begin
                                first_fail_addr_o <= cnt;
                            end
                        end
                        if (cnt == '1) begin
                            cnt <= '0;
                            if (state == ST_WRITE) begin
                                state <= ST_READ;
                            end else begin
                                // Uses the post-compare count so pass is valid alongside done.
                                pass_o <= (err_nxt == '0);
                                state  <= ST_FINISH;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_o <= 1'b1;
                        pass_o    <= 1'b0;
                        state     <= ST_FINISH;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Scoreboard bench for mem_bist_ctrl with a behavioural memory that can stall
// or corrupt individual addresses.
module tb_mem_bist_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int TO    = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          start_i = 1'b0;
    logic [1:0]    pattern_i = 2'd0;
    logic          busy_o, done_o, pass_o, timeout_o, wr_rd_o, valid_o;
    logic [AW:0]   err_cnt_o;
    logic [AW-1:0] first_fail_addr_o, addr_o;
    logic [DW-1:0] wdata_o;
    logic [DW-1:0] rdata_i = '0;
    logic          ready_i = 1'b0;

    mem_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .pattern_i(pattern_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
        .err_cnt_o(err_cnt_o), .first_fail_addr_o(first_fail_addr_o),
        .addr_o(addr_o), .wdata_o(wdata_o), .wr_rd_o(wr_rd_o), .valid_o(valid_o),
        .rdata_i(rdata_i), .ready_i(ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    typedef struct {
        logic [AW:0]   err;
        logic [AW-1:0] ffa;
        logic          pass;
        logic          tmo;
        int            hs;
        int            maxw;
    } res_t;

    txn_t txn_q[$];
    res_t res_q[$];

    int n_vec = 0;
    int n_err = 0;
    int hs_cnt = 0;
    int cur_wait = 0;
    int max_wait = 0;
    int done_cnt = 0;
    int wr_seen = 0;
    bit stall_mode = 1'b0;

    logic [DW-1:0] mem  [DEPTH];
    logic [DW-1:0] mask [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hand-written reference words for the 16-bit data width used here.
    function automatic logic [DW-1:0] ref_data(input logic [1:0] p, input logic [AW-1:0] a);
        case (p)
            2'd0:    return 16'h0000;
            2'd1:    return 16'hFFFF;
            2'd2:    return a[0] ? 16'h5555 : 16'hAAAA;
            default: return {12'h000, a};
        endcase
    endfunction

    function automatic res_t mk_res(input int err, input int ffa, input bit pass,
                                    input bit tmo, input int hs, input int maxw);
        res_t r;
        r.err  = (AW+1)'(err);
        r.ffa  = AW'(ffa);
        r.pass = pass;
        r.tmo  = tmo;
        r.hs   = hs;
        r.maxw = maxw;
        return r;
    endfunction

    // Memory: answers each request on its second cycle, optionally stalling
    // from the 4th write onwards and masking read data per address.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]  = '0;
            mask[i] = '1;
        end
        forever begin
            @(negedge clk);
            if (rst_i && valid_o && !ready_i && !(stall_mode && wr_rd_o && wr_seen >= 3)) begin
                ready_i = 1'b1;
                if (wr_rd_o) begin
                    mem[addr_o] = wdata_o;
                    wr_seen++;
                    rdata_i = '0;
                end else begin
                    rdata_i = mem[addr_o] & mask[addr_o];
                end
            end else begin
                ready_i = 1'b0;
                rdata_i = '0;
            end
        end
    end

    // Monitor: pops an expected transaction per handshake, an expected result per done.
    initial begin
        txn_t t;
        res_t r;
        forever begin
            @(negedge clk);
            #1;
            if (rst_i) begin
                if (valid_o && !ready_i) begin
                    cur_wait++;
                    if (cur_wait > max_wait) max_wait = cur_wait;
                end
                if (valid_o && ready_i) begin
                    cur_wait = 0;
                    hs_cnt++;
                    if (txn_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_hs: got addr %0h wr %0b, none expected", addr_o, wr_rd_o);
                    end else begin
                        t = txn_q.pop_front();
                        chk("hs_wr_addr_data", {11'd0, wr_rd_o, addr_o, wdata_o}, {11'd0, t.wr, t.addr, t.data});
                    end
                end
                if (done_o) begin
                    done_cnt++;
                    if (res_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_done: got done, none expected");
                    end else begin
                        r = res_q.pop_front();
                        chk("err_cnt", 32'(err_cnt_o), 32'(r.err));
                        chk("first_fail", 32'(first_fail_addr_o), 32'(r.ffa));
                        chk("pass", 32'(pass_o), 32'(r.pass));
                        chk("timeout", 32'(timeout_o), 32'(r.tmo));
                        chk("handshakes", hs_cnt, r.hs);
                        chk("max_wait", max_wait, r.maxw);
                        chk("txn_left", txn_q.size(), 0);
                    end
                    hs_cnt   = 0;
                    max_wait = 0;
                    cur_wait = 0;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic run_start(input logic [1:0] p, input int nwr, input int nrd, input res_t r);
        txn_t t;
        for (int a = 0; a < nwr; a++) begin
            t.wr = 1'b1; t.addr = AW'(a); t.data = ref_data(p, AW'(a));
            txn_q.push_back(t);
        end
        for (int a = 0; a < nrd; a++) begin
            t.wr = 1'b0; t.addr = AW'(a); t.data = '0;
            txn_q.push_back(t);
        end
        res_q.push_back(r);
        wr_seen   = 0;
        pattern_i = p;
        start_i   = 1'b1;
        cyc(1);
        start_i   = 1'b0;
    endtask

    task automatic wait_done(input int limit, input bit pulse_start);
        for (int i = 0; i < limit; i++) begin
            cyc(1);
            if (done_o) begin
                if (pulse_start) begin
                    start_i = 1'b1;
                    cyc(1);
                    start_i = 1'b0;
                end
                return;
            end
        end
        n_vec++;
        n_err++;
        $display("FAIL done_timeout: got no done within %0d cycles, required done", limit);
    endtask

    initial begin
        bit found;
        rst_i = 1'b0;
        cyc(3);
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_results", {pass_o, timeout_o, err_cnt_o, first_fail_addr_o}, 0);
        chk("rst_bus", {wr_rd_o, addr_o, wdata_o}, 0);
        rst_i = 1'b1;
        cyc(2);

        // Address-as-data on a clean memory.
        run_start(2'd3, DEPTH, DEPTH, mk_res(0, 0, 1, 0, 2*DEPTH, 1));
        wait_done(300, 1'b0);
        cyc(2);
        chk("pass_held", 32'(pass_o), 1);
        chk("busy_after", 32'(busy_o), 0);

        // All-ones with bit 0 stuck low at address 5.
        mask[5] = 16'hFFFE;
        run_start(2'd1, DEPTH, DEPTH, mk_res(1, 5, 0, 0, 2*DEPTH, 1));
        wait_done(300, 1'b0);
        mask[5] = '1;
        cyc(2);

        // Checkerboard with addresses 3 and 9 reading back zero.
        mask[3] = '0;
        mask[9] = '0;
        run_start(2'd2, DEPTH, DEPTH, mk_res(2, 3, 0, 0, 2*DEPTH, 1));
        wait_done(300, 1'b0);
        mask[9] = '1;
        cyc(2);

        // Memory stops answering at the 4th write.
        stall_mode = 1'b1;
        run_start(2'd0, 3, 0, mk_res(0, 0, 0, 1, 3, TO));
        wait_done(300, 1'b0);
        stall_mode = 1'b0;
        cyc(1);
        chk("tmo_held", 32'(timeout_o), 1);
        chk("tmo_valid_low", 32'(valid_o), 0);
        cyc(2);

        // Reset pulse while reading address 7 (one mismatch already logged at 3).
        run_start(2'd2, DEPTH, DEPTH, mk_res(0, 0, 0, 0, 0, 0));
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            cyc(1);
            if (valid_o && !wr_rd_o && addr_o == 4'd7 && !ready_i) found = 1'b1;
        end
        chk("reached_read7", 32'(found), 1);
        chk("err_before_rst", 32'(err_cnt_o), 1);
        rst_i = 1'b0;
        cyc(1);
        chk("midrst_valid", 32'(valid_o), 0);
        chk("midrst_busy", 32'(busy_o), 0);
        chk("midrst_results", {done_o, pass_o, timeout_o, err_cnt_o, first_fail_addr_o}, 0);
        rst_i = 1'b1;
        txn_q.delete();
        res_q.delete();
        hs_cnt   = 0;
        max_wait = 0;
        cur_wait = 0;
        mask[3]  = '1;
        cyc(2);

        // Fresh run with stray starts during WRITE and in the done cycle.
        run_start(2'd3, DEPTH, DEPTH, mk_res(0, 0, 1, 0, 2*DEPTH, 1));
        cyc(5);
        pattern_i = 2'd0;
        start_i   = 1'b1;
        cyc(1);
        start_i   = 1'b0;
        wait_done(300, 1'b1);
        cyc(5);
        chk("no_restart_hs", hs_cnt, 0);
        chk("no_restart_busy", 32'(busy_o), 0);
        chk("final_pass", 32'(pass_o), 1);
        chk("done_pulses", done_cnt, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required $finish before 500000");
        $fatal(1);
    end

endmodule
